usb_tx_sched: RTL

Transmit scheduler for the USB host packet path. It arbitrates between the handshake, token and data packet generators. It loads the granted packet and prepends SYNC, then serialises the packet one bit per cycle into the NRZI encoder's `bstr_in`/`bstr_in_ready` inputs, honouring stalls from the bit stuffer. It finishes each packet with EOP signalling and an inter-packet gap.

---
 rtl/usb_tx_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: USB host transmit scheduler.
// Arbitrates handshake/token/data generators (hs > tok > data), prepends SYNC,
// serialises the packet LSB first toward the NRZI encoder with stuffer stalls,
// then drives EOP (SE0) and an inter-packet J gap before re-arbitrating.
module usb_tx_sched #(
   parameter int GAP_CYC = 2,
   parameter int EOP_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        hs_req,
   input  logic [7:0]  hs_pid,
   input  logic        tok_req,
   input  logic [23:0] tok_pkt,
   input  logic        data_req,
   input  logic [87:0] data_pkt,
   input  logic        stall,
   output logic        hs_gnt,
   output logic        tok_gnt,
   output logic        data_gnt,
   output logic        hs_done,
   output logic        tok_done,
   output logic        data_done,
   output logic        bstr_out,
   output logic [1:0]  pkt_type,
   output logic        se0,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SEND, EOP, GAP} state_t;

   localparam logic [1:0] T_TOK  = 2'b01;
   localparam logic [1:0] T_DATA = 2'b10;
   localparam logic [1:0] T_HS   = 2'b11;
   localparam logic [7:0] SYNC   = 8'h80;

   state_t      state, state_n;
   logic [95:0] shreg, shreg_n;
   logic [6:0]  len, len_n;
   logic [6:0]  bcnt, bcnt_n;
   logic [1:0]  typ, typ_n;
   logic [7:0]  tcnt, tcnt_n;
   logic [2:0]  gnt_n;   // {data, tok, hs}
   logic [2:0]  done_n;  // {data, tok, hs}

   // Next-state, datapath and next-output computation.
   always_comb begin
      state_n = state;
      shreg_n = shreg;
      len_n   = len;
      bcnt_n  = bcnt;
      typ_n   = typ;
      tcnt_n  = tcnt;
      gnt_n   = 3'b000;
      done_n  = 3'b000;
      case (state)
         IDLE: begin
            if (hs_req) begin
               shreg_n = {80'd0, hs_pid, SYNC};
               len_n   = 7'd16;
               typ_n   = T_HS;
               gnt_n   = 3'b001;
            end else if (tok_req) begin
               shreg_n = {64'd0, tok_pkt, SYNC};
               len_n   = 7'd32;
               typ_n   = T_TOK;
               gnt_n   = 3'b010;
            end else if (data_req) begin
               shreg_n = {data_pkt, SYNC};
               len_n   = 7'd96;
               typ_n   = T_DATA;
               gnt_n   = 3'b100;
            end
            if (hs_req || tok_req || data_req) begin
               bcnt_n  = 7'd0;
               state_n = SEND;
            end
         end
         SEND: begin
            // A stuffer stall freezes the shifter, counter and outputs.
            if (!stall) begin
               shreg_n = shreg >> 1;
               bcnt_n  = bcnt + 7'd1;
               if (bcnt == len - 7'd1) begin
                  state_n = EOP;
                  tcnt_n  = 8'(EOP_CYC - 1);
               end
            end
         end
         EOP: begin
            if (tcnt == 8'd0) begin
               state_n = GAP;
               tcnt_n  = 8'(GAP_CYC - 1);
               case (typ)
                  T_HS:    done_n = 3'b001;
                  T_TOK:   done_n = 3'b010;
                  T_DATA:  done_n = 3'b100;
                  default: done_n = 3'b000;
               endcase
            end else begin
               tcnt_n = tcnt - 8'd1;
            end
         end
         GAP: begin
            if (tcnt == 8'd0) state_n = IDLE;
            else              tcnt_n  = tcnt - 8'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   // State/datapath registers; outputs are registered from next-state values
   // so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         shreg     <= '0;
         len       <= '0;
         bcnt      <= '0;
         typ       <= '0;
         tcnt      <= '0;
         bstr_out  <= 1'b1;
         pkt_type  <= 2'b00;
         se0       <= 1'b0;
         busy      <= 1'b0;
         hs_gnt    <= 1'b0;
         tok_gnt   <= 1'b0;
         data_gnt  <= 1'b0;
         hs_done   <= 1'b0;
         tok_done  <= 1'b0;
         data_done <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         len       <= len_n;
         bcnt      <= bcnt_n;
         typ       <= typ_n;
         tcnt      <= tcnt_n;
         bstr_out  <= (state_n == SEND) ? shreg_n[0] : 1'b1;
         pkt_type  <= (state_n == SEND) ? typ_n : 2'b00;
         se0       <= (state_n == EOP);
         busy      <= (state_n != IDLE);
         hs_gnt    <= gnt_n[0];
         tok_gnt   <= gnt_n[1];
         data_gnt  <= gnt_n[2];
         hs_done   <= done_n[0];
         tok_done  <= done_n[1];
         data_done <= done_n[2];
      end
   end

endmodule
